// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state type and data width.
package apb_pkg;

    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Request/response port plus APB bus of the single-outstanding APB master.
interface apb_master_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    import apb_pkg::*;

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_write_i;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      rsp_valid_o;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      busy_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready request in, SETUP/ACCESS out,
// one-cycle response strobe back, with a wait-state timeout that reports an error.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          HCLK,
    input logic          HRESET,
    apb_master_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_mst_state_e            r_state, w_state_next;
    logic [CNT_W-1:0]          r_wait_cnt, w_wait_cnt_next;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_rsp_valid, w_rsp_valid_next;
    logic                      r_rsp_err, w_rsp_err_next;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_next;
    logic                      w_load;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_err   <= w_rsp_err_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            if (w_load) begin
                r_paddr  <= bus.req_addr_i;
                r_pwdata <= bus.req_wdata_i;
                r_pwrite <= bus.req_write_i;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_load           = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_rsp_err_next   = r_rsp_err;
        w_rsp_rdata_next = r_rsp_rdata;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    w_load       = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_wait_cnt_next = '0;
                w_state_next    = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a ready in the last allowed cycle still completes.
                if (bus.PREADY) begin
                    w_state_next     = IDLE;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = bus.PSLVERR;
                    w_rsp_rdata_next = (!r_pwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
                end else if (TIMEOUT_CYCLES != 0 && r_wait_cnt == CNT_LAST) begin
                    w_state_next     = IDLE;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                    w_rsp_rdata_next = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.req_ready_o = (r_state == IDLE);
    assign bus.busy_o      = (r_state != IDLE);
    assign bus.PSEL        = (r_state != IDLE);
    assign bus.PENABLE     = (r_state == ACCESS);
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PWRITE      = r_pwrite;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_rdata_o = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, random transfers against a
// latency/response model, and hand-written back-to-back and reset sequences.
module tb_apb_master;

    localparam int unsigned AW = 12;
    localparam int unsigned TO = 4;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int unsigned   waits;
        logic          slverr;
        logic [31:0]   prdata;
        int unsigned   exp_lat;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    logic HCLK;
    logic HRESET;
    int   n_chk;
    int   n_fail;

    int unsigned cur_waits;
    logic        cur_slverr;
    logic [31:0] cur_prdata;
    int unsigned acc_idx;

    vec_t vecs[6];

    apb_master_if #(.APB_ADDR_WIDTH(AW)) bus_if ();

    apb_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus_if)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Slave: ready after cur_waits low ACCESS cycles; junk on the response lines otherwise.
    always @(negedge HCLK) begin
        if (bus_if.PSEL && bus_if.PENABLE) begin
            bus_if.PREADY  = (acc_idx == cur_waits);
            bus_if.PSLVERR = cur_slverr;
            bus_if.PRDATA  = cur_prdata;
            acc_idx        = acc_idx + 1;
        end else begin
            acc_idx        = 0;
            bus_if.PREADY  = 1'($urandom);
            bus_if.PSLVERR = 1'($urandom);
            bus_if.PRDATA  = $urandom;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected response from the protocol rules: waits >= TO means the slave never answers in time.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.waits >= TO) begin
            r.exp_lat = 3 + TO - 1;
            r.exp_err = 1'b1;
        end else begin
            r.exp_lat = 3 + v.waits;
            r.exp_err = v.slverr;
        end
        r.exp_rdata = (!v.write && !r.exp_err) ? v.prdata : 32'h0;
        return r;
    endfunction

    task automatic do_xfer(input vec_t v);
        int   n = 0;
        int   acc = 0;
        logic got = 1'b0;
        logic psel_ok = 1'b1;
        logic stable_ok = 1'b1;
        @(negedge HCLK);
        cur_waits             = v.waits;
        cur_slverr            = v.slverr;
        cur_prdata            = v.prdata;
        bus_if.req_valid_i    = 1'b1;
        bus_if.req_write_i    = v.write;
        bus_if.req_addr_i     = v.addr;
        bus_if.req_wdata_i    = v.wdata;
        chk("ready_in_idle", 32'(bus_if.req_ready_o), 32'd1);
        @(posedge HCLK);
        #1;
        // Keep valid asserted with junk fields: must be ignored while busy.
        bus_if.req_write_i = ~v.write;
        bus_if.req_addr_i  = AW'($urandom);
        bus_if.req_wdata_i = $urandom;
        while (!got && n < 20) begin
            @(negedge HCLK);
            n++;
            if (bus_if.rsp_valid_o) begin
                got = 1'b1;
                bus_if.req_valid_i = 1'b0;
            end else begin
                if (bus_if.PSEL !== 1'b1 || bus_if.busy_o !== 1'b1) psel_ok = 1'b0;
                if (n == 1 && bus_if.PENABLE !== 1'b0) psel_ok = 1'b0;
                if (bus_if.PENABLE === 1'b1) acc++;
                if (bus_if.PADDR !== v.addr || bus_if.PWDATA !== v.wdata ||
                    bus_if.PWRITE !== v.write) stable_ok = 1'b0;
            end
        end
        bus_if.req_valid_i = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(v.exp_lat));
        chk("rsp_err", 32'(bus_if.rsp_err_o), 32'(v.exp_err));
        chk("rsp_rdata", bus_if.rsp_rdata_o, v.exp_rdata);
        chk("access_cycles", 32'(acc), 32'(v.exp_lat - 2));
        chk("psel_penable_profile", 32'(psel_ok), 32'd1);
        chk("bus_stable", 32'(stable_ok), 32'd1);
        chk("psel_low_at_rsp", 32'(bus_if.PSEL), 32'd0);
        chk("paddr_held", 32'(bus_if.PADDR), 32'(v.addr));
        @(negedge HCLK);
        chk("rsp_one_cycle", 32'(bus_if.rsp_valid_o), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [5:0]  psel_pat;
        logic [5:0]  rsp_pat;
        logic [31:0] rd1, rd2;
        logic [1:0]  errs;
        logic        rsp_seen;
        n_chk = 0;
        n_fail = 0;
        cur_waits = 0;
        cur_slverr = 1'b0;
        cur_prdata = 32'h0;
        acc_idx = 0;
        bus_if.req_valid_i = 1'b0;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = '0;
        bus_if.req_wdata_i = '0;
        bus_if.PREADY      = 1'b0;
        bus_if.PSLVERR     = 1'b0;
        bus_if.PRDATA      = '0;

        //         write addr    wdata          waits slverr prdata        lat err rdata
        vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 0,   1'b0, 32'h00000055, 3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 12'h024, 32'h00000000, 2,   1'b0, 32'h12345678, 5, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 12'h100, 32'h00000000, 0,   1'b1, 32'hFFFFFFFF, 3, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 12'h0FC, 32'h00000000, 100, 1'b0, 32'hCAFEF00D, 6, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 12'h0F8, 32'h00000000, 3,   1'b0, 32'h0BADCAFE, 6, 1'b0, 32'h0BADCAFE};
        vecs[5] = '{1'b1, 12'hFFC, 32'h01234567, 1,   1'b1, 32'h87654321, 4, 1'b1, 32'h0};

        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        chk("rst_ready", 32'(bus_if.req_ready_o), 32'd1);
        chk("rst_ctrl", {26'd0, bus_if.PSEL, bus_if.PENABLE, bus_if.PWRITE, bus_if.rsp_valid_o,
                         bus_if.rsp_err_o, bus_if.busy_o}, 32'd0);
        chk("rst_paddr", 32'(bus_if.PADDR), 32'd0);
        chk("rst_pwdata", bus_if.PWDATA, 32'd0);
        chk("rst_rdata", bus_if.rsp_rdata_o, 32'd0);
        HRESET = 1'b0;

        for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v.write  = 1'($urandom);
            v.addr   = AW'($urandom);
            v.wdata  = $urandom;
            v.waits  = $urandom_range(0, 6);
            v.slverr = ($urandom_range(0, 3) == 0);
            v.prdata = $urandom;
            do_xfer(model(v));
        end

        // Back-to-back: write then read with valid held high throughout.
        @(negedge HCLK);
        cur_waits          = 0;
        cur_slverr         = 1'b0;
        cur_prdata         = 32'hA5A50F0F;
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = 1'b1;
        bus_if.req_addr_i  = 12'h020;
        bus_if.req_wdata_i = 32'h11112222;
        @(posedge HCLK);
        #1;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = 12'h030;
        bus_if.req_wdata_i = 32'h0;
        rd1 = 32'hX;
        rd2 = 32'hX;
        errs = 2'b11;
        for (int n = 1; n <= 6; n++) begin
            @(negedge HCLK);
            psel_pat[n-1] = bus_if.PSEL;
            rsp_pat[n-1]  = bus_if.rsp_valid_o;
            if (n == 3) begin
                rd1 = bus_if.rsp_rdata_o;
                errs[0] = bus_if.rsp_err_o;
            end
            if (n == 4) begin
                bus_if.req_valid_i = 1'b0;
                chk("b2b_second_paddr", 32'(bus_if.PADDR), 32'h030);
            end
            if (n == 6) begin
                rd2 = bus_if.rsp_rdata_o;
                errs[1] = bus_if.rsp_err_o;
            end
        end
        chk("b2b_psel_pattern", 32'(psel_pat), 32'b011011);
        chk("b2b_rsp_pattern", 32'(rsp_pat), 32'b100100);
        chk("b2b_rsp1_rdata", rd1, 32'h0);
        chk("b2b_rsp2_rdata", rd2, 32'hA5A50F0F);
        chk("b2b_errs", 32'(errs), 32'd0);

        // Reset in the middle of an ACCESS wait state.
        @(negedge HCLK);
        cur_waits          = 50;
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = 12'h044;
        @(posedge HCLK);
        #1;
        bus_if.req_valid_i = 1'b0;
        repeat (2) @(negedge HCLK);
        chk("mid_access_penable", 32'(bus_if.PENABLE), 32'd1);
        HRESET = 1'b1;
        #1;
        chk("rst_mid_psel_penable", {30'd0, bus_if.PSEL, bus_if.PENABLE}, 32'd0);
        chk("rst_mid_busy", 32'(bus_if.busy_o), 32'd0);
        rsp_seen = 1'b0;
        repeat (2) begin
            @(negedge HCLK);
            if (bus_if.rsp_valid_o !== 1'b0) rsp_seen = 1'b1;
        end
        HRESET = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            if (bus_if.rsp_valid_o !== 1'b0 || bus_if.PSEL !== 1'b0) rsp_seen = 1'b1;
        end
        chk("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);
        chk("rst_mid_paddr", 32'(bus_if.PADDR), 32'd0);
        v = '{1'b0, 12'h048, 32'h0, 0, 1'b0, 32'h600DF00D, 0, 1'b0, 32'h0};
        do_xfer(model(v));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
